// File: rtl/pipe_stage_regs.sv
// Y86 pipeline register bank (F, D, E, M, W) driven by hazard-unit stall/bubble controls.
// Optional saturating stall/bubble counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_stage_regs #(
  parameter int          CNT_W  = 32,
  parameter logic [63:0] RST_PC = 64'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             F_stall,
  input  logic             D_stall,
  input  logic             D_bubble,
  input  logic             E_bubble,
  input  logic             M_bubble,
  input  logic             W_stall,
  input  logic [63:0]      f_predPC,
  output logic [63:0]      F_predPC,
  input  logic [146:0]     d_in,
  output logic [146:0]     D_out,
  input  logic [218:0]     e_in,
  output logic [218:0]     E_out,
  input  logic [143:0]     m_in,
  output logic [143:0]     M_out,
  input  logic [142:0]     w_in,
  output logic [142:0]     W_out,
  output logic             ctl_conflict,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_bubble_cnt
);

  localparam logic [2:0]  SAOK  = 3'd1;
  localparam logic [3:0]  INOP  = 4'h1;
  localparam logic [3:0]  RNONE = 4'hF;
  localparam logic [63:0] ZERO64 = 64'd0;

  // NOP bundles: status AOK, icode NOP, register IDs RNONE, data zero
  localparam logic [146:0] D_BUBBLE = {SAOK, INOP, 4'h0, RNONE, RNONE, ZERO64, ZERO64};
  localparam logic [218:0] E_BUBBLE = {SAOK, INOP, 4'h0, ZERO64, ZERO64, ZERO64,
                                       RNONE, RNONE, RNONE, RNONE};
  localparam logic [143:0] M_BUBBLE = {SAOK, INOP, 1'b0, ZERO64, ZERO64, RNONE, RNONE};
  localparam logic [142:0] W_BUBBLE = {SAOK, INOP, ZERO64, ZERO64, RNONE, RNONE};

  logic [63:0]  f_pc_reg,   f_pc_next;
  logic [146:0] d_reg,      d_next;
  logic [218:0] e_reg,      e_next;
  logic [143:0] m_reg,      m_next;
  logic [142:0] w_reg,      w_next;
  logic         conflict_reg, conflict_next;

  always_comb begin
    f_pc_next = F_stall ? f_pc_reg : f_predPC;

    // A stall on D outranks a bubble request for the same edge
    d_next = d_in;
    if (D_stall) begin
      d_next = d_reg;
    end else if (D_bubble) begin
      d_next = D_BUBBLE;
    end

    e_next        = E_bubble ? E_BUBBLE : e_in;
    m_next        = M_bubble ? M_BUBBLE : m_in;
    w_next        = W_stall  ? w_reg    : w_in;
    conflict_next = conflict_reg | (D_stall & D_bubble);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_pc_reg     <= RST_PC;
      d_reg        <= D_BUBBLE;
      e_reg        <= E_BUBBLE;
      m_reg        <= M_BUBBLE;
      w_reg        <= W_BUBBLE;
      conflict_reg <= 1'b0;
    end else begin
      f_pc_reg     <= f_pc_next;
      d_reg        <= d_next;
      e_reg        <= e_next;
      m_reg        <= m_next;
      w_reg        <= w_next;
      conflict_reg <= conflict_next;
    end
  end

  assign F_predPC     = f_pc_reg;
  assign D_out        = d_reg;
  assign E_out        = e_reg;
  assign M_out        = m_reg;
  assign W_out        = w_reg;
  assign ctl_conflict = conflict_reg;

`ifdef PIPE_PERF_CNT_EN
  logic [1:0] perf_evt;
  assign perf_evt = {E_bubble, D_stall};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_perf
      logic [CNT_W-1:0] cnt_reg, cnt_next;

      // Saturate at all-ones instead of wrapping
      always_comb begin
        cnt_next = cnt_reg;
        if (perf_evt[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_next = cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end
    end
  endgenerate

  assign perf_stall_cnt  = g_perf[0].cnt_reg;
  assign perf_bubble_cnt = g_perf[1].cnt_reg;
`else
  assign perf_stall_cnt  = '0;
  assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Randomized + directed bench for pipe_stage_regs against a field-level reference model.
module tb_pipe_stage_regs;

  localparam int          CNT_W  = 4;
  localparam logic [63:0] RST_PC = 64'h0000_0000_0000_1000;
  localparam int          SAT    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
  logic [63:0]      f_predPC, F_predPC;
  logic [146:0]     d_in, D_out;
  logic [218:0]     e_in, E_out;
  logic [143:0]     m_in, M_out;
  logic [142:0]     w_in, W_out;
  logic             ctl_conflict;
  logic [CNT_W-1:0] perf_stall_cnt, perf_bubble_cnt;

  pipe_stage_regs #(.CNT_W(CNT_W), .RST_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .f_predPC(f_predPC), .F_predPC(F_predPC),
    .d_in(d_in), .D_out(D_out), .e_in(e_in), .E_out(E_out),
    .m_in(m_in), .M_out(M_out), .w_in(w_in), .W_out(W_out),
    .ctl_conflict(ctl_conflict),
    .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Bundles assembled from named fields
  function automatic logic [146:0] d_pack(logic [2:0] stat, logic [3:0] icode, logic [3:0] ifun,
                                          logic [3:0] ra, logic [3:0] rb, logic [63:0] valc, logic [63:0] valp);
    return {stat, icode, ifun, ra, rb, valc, valp};
  endfunction
  function automatic logic [218:0] e_pack(logic [2:0] stat, logic [3:0] icode, logic [3:0] ifun,
                                          logic [63:0] valc, logic [63:0] vala, logic [63:0] valb,
                                          logic [3:0] dste, logic [3:0] dstm, logic [3:0] srca, logic [3:0] srcb);
    return {stat, icode, ifun, valc, vala, valb, dste, dstm, srca, srcb};
  endfunction
  function automatic logic [143:0] m_pack(logic [2:0] stat, logic [3:0] icode, logic cnd,
                                          logic [63:0] vale, logic [63:0] vala, logic [3:0] dste, logic [3:0] dstm);
    return {stat, icode, cnd, vale, vala, dste, dstm};
  endfunction
  function automatic logic [142:0] w_pack(logic [2:0] stat, logic [3:0] icode, logic [63:0] vale,
                                          logic [63:0] valm, logic [3:0] dste, logic [3:0] dstm);
    return {stat, icode, vale, valm, dste, dstm};
  endfunction

  logic [146:0] nop_d;
  logic [218:0] nop_e;
  logic [143:0] nop_m;
  logic [142:0] nop_w;

  // Reference state
  logic [63:0]  exp_f;
  logic [146:0] exp_d;
  logic [218:0] exp_e;
  logic [143:0] exp_m;
  logic [142:0] exp_w;
  logic         exp_conf;
  int           n_dstall, n_ebub;

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic rand_data();
    logic [255:0] r;
    r = rnd256(); f_predPC = r[63:0];
    r = rnd256(); d_in = r[146:0];
    r = rnd256(); e_in = r[218:0];
    r = rnd256(); m_in = r[143:0];
    r = rnd256(); w_in = r[142:0];
  endtask

  task automatic set_ctl(input logic fs, ds, db, eb, mb, ws);
    F_stall = fs; D_stall = ds; D_bubble = db; E_bubble = eb; M_bubble = mb; W_stall = ws;
  endtask

  task automatic model_reset();
    exp_f = RST_PC; exp_d = nop_d; exp_e = nop_e; exp_m = nop_m; exp_w = nop_w;
    exp_conf = 1'b0; n_dstall = 0; n_ebub = 0;
  endtask

  task automatic check_all(input string ctx);
    int es, eb;
    check({ctx, ".F"}, F_predPC, exp_f);
    check({ctx, ".D"}, D_out, exp_d);
    check({ctx, ".E"}, E_out, exp_e);
    check({ctx, ".M"}, M_out, exp_m);
    check({ctx, ".W"}, W_out, exp_w);
    check({ctx, ".conflict"}, ctl_conflict, exp_conf);
`ifdef PIPE_PERF_CNT_EN
    es = (n_dstall > SAT) ? SAT : n_dstall;
    eb = (n_ebub   > SAT) ? SAT : n_ebub;
`else
    es = 0;
    eb = 0;
`endif
    check({ctx, ".stall_cnt"}, perf_stall_cnt, es);
    check({ctx, ".bubble_cnt"}, perf_bubble_cnt, eb);
  endtask

  // One rising edge: advance the model with the applied inputs, then compare
  task automatic tick(input string ctx);
    @(posedge clk);
    if (!F_stall) exp_f = f_predPC;
    if (!D_stall) exp_d = D_bubble ? nop_d : d_in;
    exp_e = E_bubble ? nop_e : e_in;
    exp_m = M_bubble ? nop_m : m_in;
    if (!W_stall) exp_w = w_in;
    if (D_stall && D_bubble) exp_conf = 1'b1;
    if (D_stall) n_dstall++;
    if (E_bubble) n_ebub++;
    #1;
    check_all(ctx);
  endtask

  // Asynchronous reset pulse placed between edges
  task automatic pulse_reset(input string ctx);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all(ctx);
    check({ctx, ".e_icode"}, E_out[215:212], 4'h1);
    check({ctx, ".e_dstE"}, E_out[15:12], 4'hF);
    rst_n = 1'b1;
  endtask

  initial begin
    nop_d = d_pack(3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0);
    nop_e = e_pack(3'd1, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 4'hF, 4'hF);
    nop_m = m_pack(3'd1, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF);
    nop_w = w_pack(3'd1, 4'h1, 64'd0, 64'd0, 4'hF, 4'hF);

    rst_n = 1'b0;
    set_ctl(0, 0, 0, 0, 0, 0);
    rand_data();
    model_reset();
    #12 check_all("reset");
    rst_n = 1'b1;

    // Random phase
    for (int i = 0; i < 200; i++) begin
      rand_data();
      set_ctl($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      tick("rand");
    end

    // Reset mid-run with nonzero bundles applied
    rand_data();
    pulse_reset("midreset");

    // Load then load-use hazard
    set_ctl(0, 0, 0, 0, 0, 0); rand_data(); tick("preload");
    rand_data(); d_in[143:140] = 4'h6;
    set_ctl(1, 1, 0, 1, 0, 0); tick("loaduse");
    check("loaduse.e_nop", E_out, nop_e);
    set_ctl(0, 0, 0, 0, 0, 0); rand_data(); tick("loaduse_next");
    check("loaduse.e_load", E_out, e_in);

    // Mispredict
    rand_data(); f_predPC = 64'h40;
    set_ctl(0, 0, 1, 1, 0, 0); tick("mispredict");
    check("mispredict.pc", F_predPC, 64'h40);

    // Conflict: stall wins, flag is sticky
    rand_data(); set_ctl(0, 1, 1, 0, 0, 0); tick("conflict");
    check("conflict.flag", ctl_conflict, 1'b1);
    for (int i = 0; i < 3; i++) begin
      rand_data(); set_ctl(0, 0, 0, 0, 0, 0); tick("conflict_sticky");
    end

    // Exception freeze in W
    rand_data(); w_in[142:140] = 3'd4; set_ctl(0, 0, 0, 0, 0, 0); tick("exc_load");
    for (int i = 0; i < 5; i++) begin
      rand_data(); set_ctl(0, 0, 0, 0, 1, 1); tick("exc_freeze");
      check("exc.w_stat", W_out[142:140], 3'd4);
    end

    // Counter saturation
    pulse_reset("perf_reset");
    for (int i = 0; i < 20; i++) begin
      rand_data(); set_ctl(0, 1, 0, i[0], 0, 0); tick("perf");
    end
`ifdef PIPE_PERF_CNT_EN
    check("perf.sat", perf_stall_cnt, SAT);
`else
    check("perf.off", perf_stall_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
